// File: rtl/btb_if.sv
// Fetch/execute-side signals of the branch target buffer.
// The pipeline drives through the master view; the BTB answers through the slave view.
interface btb_if;
  logic        stallD;
  logic        flushD;
  logic        flushE;
  logic        flushM;
  logic [31:0] pcF;
  logic        branchM;
  logic        actual_takeM;
  logic [31:0] pcM;
  logic [31:0] actual_targetM;
  logic        hitF;
  logic [31:0] targetF;
  logic        hitD;
  logic [31:0] targetD;
  logic        target_wrongM;
  logic [15:0] hit_count;

  modport master (
    output stallD, flushD, flushE, flushM, pcF,
    output branchM, actual_takeM, pcM, actual_targetM,
    input  hitF, targetF, hitD, targetD, target_wrongM, hit_count
  );

  modport slave (
    input  stallD, flushD, flushE, flushM, pcF,
    input  branchM, actual_takeM, pcM, actual_targetM,
    output hitF, targetF, hitD, targetD, target_wrongM, hit_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: looked up with pcF, trained from M,
// with hit/target carried F->D->E->M so M can flag missing or wrong targets.
module branch_target_buffer #(
  parameter int BTB_DEPTH = 6,
  parameter int TAG_W     = 8
) (
  input logic  clk,
  input logic  rst,
  btb_if.slave bus
);
  localparam int Entries = 1 << BTB_DEPTH;
  localparam int TagLo   = BTB_DEPTH + 2;
  localparam int TagHi   = BTB_DEPTH + TAG_W + 1;

  logic [Entries-1:0] validQ;
  logic [TAG_W-1:0]   tagMem    [Entries];
  logic [31:0]        targetMem [Entries];

  logic [BTB_DEPTH-1:0] idxF, idxM;
  logic [TAG_W-1:0]     tagF, tagM;
  logic                 hitF;
  logic [31:0]          targetF;
  logic                 writeEn;

  logic        hitD, hitE, hitM;
  logic [31:0] targetD, targetE, targetM;
  logic        targetMatchM;
  logic [15:0] hitCount;

  // Only the index/tag window of the PC takes part in lookup and training.
  logic unusedPcBits;
  assign unusedPcBits = ^{bus.pcF[1:0], bus.pcF[31:TagHi+1],
                          bus.pcM[1:0], bus.pcM[31:TagHi+1]};

  assign idxF = bus.pcF[BTB_DEPTH+1:2];
  assign tagF = bus.pcF[TagHi:TagLo];
  assign idxM = bus.pcM[BTB_DEPTH+1:2];
  assign tagM = bus.pcM[TagHi:TagLo];

  assign hitF    = validQ[idxF] && (tagMem[idxF] == tagF);
  assign targetF = hitF ? targetMem[idxF] : 32'h0;

  assign writeEn = bus.branchM & bus.actual_takeM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= '0;
    end else if (writeEn) begin
      validQ[idxM] <= 1'b1;
    end
  end

  // Tag/target storage has no reset; a cleared valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      tagMem[idxM]    <= tagM;
      targetMem[idxM] <= bus.actual_targetM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitD    <= 1'b0;
      targetD <= 32'h0;
      hitE    <= 1'b0;
      targetE <= 32'h0;
      hitM    <= 1'b0;
      targetM <= 32'h0;
    end else begin
      if (bus.flushD) begin
        hitD    <= 1'b0;
        targetD <= 32'h0;
      end else if (!bus.stallD) begin
        hitD    <= hitF;
        targetD <= targetF;
      end
      if (bus.flushE) begin
        hitE    <= 1'b0;
        targetE <= 32'h0;
      end else begin
        hitE    <= hitD;
        targetE <= targetD;
      end
      if (bus.flushM) begin
        hitM    <= 1'b0;
        targetM <= 32'h0;
      end else begin
        hitM    <= hitE;
        targetM <= targetE;
      end
    end
  end

  assign targetMatchM = (targetM == bus.actual_targetM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitCount <= 16'h0;
    end else if (bus.branchM && hitM && targetMatchM && (hitCount != 16'hFFFF)) begin
      hitCount <= hitCount + 16'h1;
    end
  end

  assign bus.hitF          = hitF;
  assign bus.targetF       = targetF;
  assign bus.hitD          = hitD;
  assign bus.targetD       = targetD;
  assign bus.target_wrongM = bus.branchM & bus.actual_takeM & (~hitM | ~targetMatchM);
  assign bus.hit_count     = hitCount;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized checks of branch_target_buffer against a table/pipeline
// reference model built from associative arrays.
module tb_branch_target_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  btb_if bus ();

  branch_target_buffer #(.BTB_DEPTH(6), .TAG_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: table keyed by index, plus the three pipeline stages D/E/M.
  logic [7:0]  refTag [int];
  logic [31:0] refTgt [int];
  logic        pHit [3];
  logic [31:0] pTgt [3];
  int          refCount;

  function automatic int idxOf(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic [7:0] tagOf(logic [31:0] pc);
    return 8'((pc >> 8) % 256);
  endfunction

  function automatic logic refHit(logic [31:0] pc);
    if (!refTag.exists(idxOf(pc))) return 1'b0;
    return refTag[idxOf(pc)] == tagOf(pc);
  endfunction

  function automatic logic [31:0] refTarget(logic [31:0] pc);
    if (!refHit(pc)) return 32'h0;
    return refTgt[idxOf(pc)];
  endfunction

  task automatic modelReset();
    refTag.delete();
    refTgt.delete();
    for (int s = 0; s < 3; s++) begin
      pHit[s] = 1'b0;
      pTgt[s] = 32'h0;
    end
    refCount = 0;
  endtask

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic checkAll(string name);
    logic expWrong;
    expWrong = bus.branchM && bus.actual_takeM && (!pHit[2] || (pTgt[2] != bus.actual_targetM));
    chk({name, ".hitF"}, 32'(bus.hitF), 32'(refHit(bus.pcF)));
    chk({name, ".targetF"}, bus.targetF, refTarget(bus.pcF));
    chk({name, ".hitD"}, 32'(bus.hitD), 32'(pHit[0]));
    chk({name, ".targetD"}, bus.targetD, pTgt[0]);
    chk({name, ".wrongM"}, 32'(bus.target_wrongM), 32'(expWrong));
    chk({name, ".count"}, 32'(bus.hit_count), 32'(refCount));
  endtask

  task automatic modelTick();
    logic        fh;
    logic [31:0] ft;
    fh = refHit(bus.pcF);
    ft = refTarget(bus.pcF);
    if (bus.branchM && pHit[2] && (pTgt[2] == bus.actual_targetM) && refCount < 65535)
      refCount++;
    if (bus.branchM && bus.actual_takeM) begin
      refTag[idxOf(bus.pcM)] = tagOf(bus.pcM);
      refTgt[idxOf(bus.pcM)] = bus.actual_targetM;
    end
    pHit[2] = bus.flushM ? 1'b0 : pHit[1];
    pTgt[2] = bus.flushM ? 32'h0 : pTgt[1];
    pHit[1] = bus.flushE ? 1'b0 : pHit[0];
    pTgt[1] = bus.flushE ? 32'h0 : pTgt[0];
    if (bus.flushD) begin
      pHit[0] = 1'b0;
      pTgt[0] = 32'h0;
    end else if (!bus.stallD) begin
      pHit[0] = fh;
      pTgt[0] = ft;
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic adv();
    modelTick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pcHist [3];
  logic [31:0] pc;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.stallD = 1'b0;
    bus.flushD = 1'b0;
    bus.flushE = 1'b0;
    bus.flushM = 1'b0;
    bus.pcF = 32'h100;
    bus.branchM = 1'b0;
    bus.actual_takeM = 1'b0;
    bus.pcM = 32'h0;
    bus.actual_targetM = 32'h0;
    modelReset();

    settle();
    checkAll("reset");
    chk("reset_hitF", 32'(bus.hitF), 32'h0);
    chk("reset_count", 32'(bus.hit_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Cold taken branch; same-cycle lookup of that PC still misses.
    bus.pcF = 32'h0040_0010;
    bus.branchM = 1'b1;
    bus.actual_takeM = 1'b1;
    bus.pcM = 32'h0040_0010;
    bus.actual_targetM = 32'h0040_0080;
    settle();
    checkAll("cold");
    chk("cold_wrongM", 32'(bus.target_wrongM), 32'h1);
    chk("cold_nobypass", 32'(bus.hitF), 32'h0);
    adv();

    bus.branchM = 1'b0;
    bus.actual_takeM = 1'b0;
    settle();
    checkAll("cold_lookup");
    chk("cold_hitF", 32'(bus.hitF), 32'h1);
    chk("cold_targetF", bus.targetF, 32'h0040_0080);
    adv();
    bus.pcF = 32'h100;
    settle();
    chk("hitD_follow", 32'(bus.hitD), 32'h1);
    adv();
    adv();

    // Same branch now in M with hitM/targetM correct.
    bus.branchM = 1'b1;
    bus.actual_takeM = 1'b1;
    bus.pcM = 32'h0040_0010;
    bus.actual_targetM = 32'h0040_0080;
    settle();
    checkAll("hit");
    chk("hit_wrongM", 32'(bus.target_wrongM), 32'h0);
    adv();
    bus.branchM = 1'b0;
    settle();
    chk("hit_count1", 32'(bus.hit_count), 32'h1);

    // Alias at the same index with a different tag overwrites the entry.
    bus.branchM = 1'b1;
    bus.actual_takeM = 1'b1;
    bus.pcM = 32'h0040_1010;
    bus.actual_targetM = 32'h0040_2000;
    adv();
    bus.branchM = 1'b0;
    bus.pcF = 32'h0040_0010;
    settle();
    checkAll("alias_old");
    chk("alias_old_miss", 32'(bus.hitF), 32'h0);
    adv();
    bus.pcF = 32'h0040_1010;
    settle();
    checkAll("alias_new");
    chk("alias_new_tgt", bus.targetF, 32'h0040_2000);

    // Not-taken branch leaves the entry alone.
    bus.branchM = 1'b1;
    bus.actual_takeM = 1'b0;
    bus.pcM = 32'h0040_1010;
    bus.actual_targetM = 32'h1234_5678;
    settle();
    checkAll("nt");
    chk("nt_wrongM", 32'(bus.target_wrongM), 32'h0);
    adv();
    bus.branchM = 1'b0;
    settle();
    chk("nt_kept", bus.targetF, 32'h0040_2000);
    adv();

    // Stall holds D for 3 edges; flush together with stall clears it.
    bus.stallD = 1'b1;
    bus.pcF = 32'h100;
    for (int i = 0; i < 3; i++) begin
      adv();
      settle();
      chk("stall_hitD", 32'(bus.hitD), 32'h1);
      chk("stall_targetD", bus.targetD, 32'h0040_2000);
    end
    bus.flushD = 1'b1;
    adv();
    bus.flushD = 1'b0;
    bus.stallD = 1'b0;
    settle();
    checkAll("flushD");
    chk("flushD_hitD", 32'(bus.hitD), 32'h0);
    adv();

    // flushM drops the hit, so the taken branch reports a wrong target.
    bus.pcF = 32'h0040_1010;
    adv();
    bus.pcF = 32'h100;
    adv();
    bus.flushM = 1'b1;
    adv();
    bus.flushM = 1'b0;
    bus.branchM = 1'b1;
    bus.actual_takeM = 1'b1;
    bus.pcM = 32'h0040_1010;
    bus.actual_targetM = 32'h0040_2000;
    settle();
    checkAll("flushM");
    chk("flushM_wrongM", 32'(bus.target_wrongM), 32'h1);
    adv();

    // Randomized traffic; M replays the PC fetched three cycles earlier.
    for (int s = 0; s < 3; s++) pcHist[s] = 32'h0040_0000;
    for (int i = 0; i < 400; i++) begin
      pc = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 8)
         | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      bus.pcF = pc;
      bus.stallD = ($urandom_range(0, 9) == 0);
      bus.flushD = ($urandom_range(0, 14) == 0);
      bus.flushE = ($urandom_range(0, 14) == 0);
      bus.flushM = ($urandom_range(0, 14) == 0);
      bus.branchM = ($urandom_range(0, 1) == 1);
      bus.actual_takeM = ($urandom_range(0, 9) < 6);
      bus.pcM = pcHist[2];
      bus.actual_targetM = ($urandom_range(0, 3) != 0) ? (pcHist[2] & 32'hFFFF_FFFC) + 32'h100
                                                      : $urandom();
      if (i == 200) begin
        rst = 1'b0;
        #1;
        modelReset();
        checkAll("midreset");
        rst = 1'b1;
        #1;
      end
      settle();
      checkAll("rand");
      adv();
      pcHist[2] = pcHist[1];
      pcHist[1] = pcHist[0];
      pcHist[0] = pc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer for the fetch stage, working alongside the global-history direction predictor. It is looked up with pcF every cycle and carries hit/target F->D->E->M, mirroring the direction predictor's prediction pipeline. It is trained from the M stage with the resolved branch outcome and target. In M it flags taken branches whose target was missing or wrong, so the redirect logic can flush.

## Interface
- BTB_DEPTH, 6, index bits; table has 2^BTB_DEPTH entries
- TAG_W, 8, tag bits stored per entry
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stallD  in  1  hold F->D register
- flushD  in  1  clear F->D register
- flushE  in  1  clear D->E register
- flushM  in  1  clear E->M register
- pcF  in  32  fetch PC (lookup)
- branchM  in  1  M-stage instruction is a branch
- actual_takeM  in  1  resolved direction in M
- pcM  in  32  PC of M-stage instruction
- actual_targetM  in  32  resolved target in M
- hitF  out  1  combinational lookup hit for pcF
- targetF  out  32  combinational stored target (0 when miss)
- hitD  out  1  registered hit for D-stage instruction
- targetD  out  32  registered target for D-stage instruction
- target_wrongM  out  1  taken branch in M had no/incorrect BTB target
- hit_count  out  16  saturating count of M-stage branches that hit with correct target

## Operation
- Index = pc[BTB_DEPTH+1:2]; tag = pc[BTB_DEPTH+TAG_W+1:BTB_DEPTH+2]; bits [1:0] ignored.
- Entry = {valid, tag[TAG_W-1:0], target[31:0]}.
- Lookup (F): hitF = valid & tag match at index(pcF); targetF = stored target if hitF, else 32'h0.
- Pipeline: {hit, target} registered F->D (enable ~stallD, clear flushD), D->E (clear flushE), E->M (clear flushM). Clear has priority over enable. Cleared value: hit=0, target=0.
- Update (M), only when branchM=1:
  - actual_takeM=1: write entry at index(pcM) with valid=1, tag(pcM), actual_targetM. This allocates or overwrites, including a different-tag occupant.
  - actual_takeM=0: no table write; existing entry is kept.
  - branchM=0: no write.
- target_wrongM = branchM & actual_takeM & (~hitM | targetM != actual_targetM). It is combinational from the M pipeline register and the inputs.
- hit_count increments by 1 when branchM & hitM & (targetM == actual_targetM). It saturates at 16'hFFFF.

## Timing
- rst low, asynchronously: all valid bits 0; all pipeline hit/target regs 0; hit_count 0. Consequences: hitF=0, targetF=0, hitD=0, targetD=0, target_wrongM=0.
- Tag and target arrays need not be reset; valid=0 masks them.
- Lookup latency: hitF/targetF are combinational in the same cycle as pcF. hitD/targetD follow one cycle later, unless stalled or flushed.
- Update latency: a write at edge N is visible to lookups from cycle N+1 onward.
- Same-cycle update and lookup to the same index: the lookup returns the pre-write contents (no bypass).
- Stall and flush on the same edge: flush wins, and the D register is cleared.
- Reset asserted mid-operation: all state is lost immediately. After release, every lookup misses until it is retrained.

## Test plan
- Reset: drive rst low with pcF=0x100 -> hitF=0, hitD=0, hit_count=0, target_wrongM=0.
- Cold taken branch: branchM=1, actual_takeM=1, pcM=0x0040_0010, actual_targetM=0x0040_0080, hitM=0 -> target_wrongM=1. On the next cycle, pcF=0x0040_0010 gives hitF=1 and targetF=0x0040_0080.
- Correct hit: the same branch reaches M carrying hitM=1 and targetM=0x0040_0080 -> target_wrongM=0 and hit_count increments by 1.
- Alias/tag mismatch: pcM=0x0040_1010 (same index, different tag) taken to 0x0040_2000 overwrites the entry -> pcF=0x0040_0010 misses and pcF=0x0040_1010 hits with 0x0040_2000.
- Not-taken branch: branchM=1, actual_takeM=0 -> entry unchanged and target_wrongM=0.
- Pipeline control: stallD=1 holds hitD/targetD across 3 cycles. flushD=1 together with stallD=1 clears them to 0. flushM clears hitM, so a taken branch then reports target_wrongM=1.
